// File: rtl/pipe_collision_ctrl.sv
// Collision controller: samples the in-scope pipe and the bird on each game Tick, evaluates
// the overlap one edge later, and confirms a hit over several samples before raising Stop.
module pipe_collision_ctrl #(
   parameter int BIRD_X      = 300,
   parameter int BIRD_SIZE   = 20,
   parameter int FLOOR_Y     = 460,
   parameter int HIT_CONFIRM = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Tick,
   input  logic       Q_Count,
   input  logic       Ack,
   input  logic [9:0] X_Edge_L,
   input  logic [9:0] X_Edge_R,
   input  logic [9:0] Gap_Top,
   input  logic [9:0] Gap_Bot,
   input  logic [9:0] Bird_Y,
   input  logic [3:0] Score,
   output logic       Stop,
   output logic [3:0] Final_Score,
   output logic [3:0] Best_Score,
   output logic       Q_Idle,
   output logic       Q_Check,
   output logic       Q_Hit
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b001,
      S_CHECK = 3'b010,
      S_HIT   = 3'b100
   } state_e;

   localparam logic [10:0] BIRD_L       = 11'(BIRD_X);
   localparam logic [10:0] BIRD_R       = 11'(BIRD_X + BIRD_SIZE - 1);
   localparam logic [10:0] BIRD_EXT     = 11'(BIRD_SIZE - 1);
   localparam logic [10:0] FLOOR_ROW    = 11'(FLOOR_Y);
   localparam logic [10:0] X_MAX        = 11'd639;
   localparam logic [2:0]  CONFIRM_LAST = 3'(HIT_CONFIRM - 1);

   state_e      state_q, state_d;
   logic        stop_q, stop_d;
   logic [2:0]  hit_cnt_q, hit_cnt_d;
   logic        sample_valid_q, sample_valid_d;
   logic [9:0]  x_l_q, x_l_d, x_r_q, x_r_d;
   logic [9:0]  gap_top_q, gap_top_d, gap_bot_q, gap_bot_d;
   logic [9:0]  bird_y_q, bird_y_d;
   logic [3:0]  score_q, score_d;
   logic [3:0]  final_q, final_d, best_q, best_d;

   logic [10:0] xl, xr, bird_top, bird_bot;
   logic        x_hit, y_hit, floor_hit, overlap;

   // Evaluation on the registered sample; all arithmetic in 11 bits so nothing wraps.
   always_comb begin
      xl       = {1'b0, x_l_q};
      xr       = {1'b0, x_r_q};
      bird_top = {1'b0, bird_y_q};
      bird_bot = bird_top + BIRD_EXT;
      if (xl <= xr) begin
         x_hit = (BIRD_L <= xr) && (BIRD_R >= xl);
      end else begin
         // Pipe straddles the screen edge: test [L,639] and [0,R] separately.
         x_hit = ((BIRD_L <= X_MAX) && (BIRD_R >= xl)) || (BIRD_L <= xr);
      end
      y_hit     = (bird_top < {1'b0, gap_top_q}) || (bird_bot > {1'b0, gap_bot_q});
      floor_hit = bird_bot >= FLOOR_ROW;
      overlap   = (x_hit && y_hit) || floor_hit;
   end

   // NOTE: every _d gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_d        = state_q;
      stop_d         = stop_q;
      hit_cnt_d      = hit_cnt_q;
      sample_valid_d = 1'b0;
      x_l_d          = x_l_q;
      x_r_d          = x_r_q;
      gap_top_d      = gap_top_q;
      gap_bot_d      = gap_bot_q;
      bird_y_d       = bird_y_q;
      score_d        = score_q;
      final_d        = final_q;
      best_d         = best_q;

      case (state_q)
         S_IDLE: begin
            stop_d    = 1'b0;
            hit_cnt_d = '0;
            if (Q_Count) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (!Q_Count) begin
               state_d   = S_IDLE;
               hit_cnt_d = '0;
            end else begin
               if (Tick) begin
                  x_l_d          = X_Edge_L;
                  x_r_d          = X_Edge_R;
                  gap_top_d      = Gap_Top;
                  gap_bot_d      = Gap_Bot;
                  bird_y_d       = Bird_Y;
                  score_d        = Score;
                  sample_valid_d = 1'b1;
               end
               if (sample_valid_q) begin
                  if (overlap && (hit_cnt_q == CONFIRM_LAST)) begin
                     state_d   = S_HIT;
                     stop_d    = 1'b1;
                     hit_cnt_d = '0;
                     final_d   = score_q;
                     if (score_q > best_q) best_d = score_q;
                  end else if (overlap) begin
                     hit_cnt_d = hit_cnt_q + 3'd1;
                  end else begin
                     hit_cnt_d = '0;
                  end
               end
            end
         end
         S_HIT: begin
            stop_d = 1'b1;
            if (Ack) begin
               state_d = S_IDLE;
               stop_d  = 1'b0;
            end
         end
         default: begin
            state_d   = S_IDLE;
            stop_d    = 1'b0;
            hit_cnt_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         stop_q         <= 1'b0;
         hit_cnt_q      <= '0;
         sample_valid_q <= 1'b0;
         x_l_q          <= '0;
         x_r_q          <= '0;
         gap_top_q      <= '0;
         gap_bot_q      <= '0;
         bird_y_q       <= '0;
         score_q        <= '0;
         final_q        <= '0;
         best_q         <= '0;
      end else begin
         state_q        <= state_d;
         stop_q         <= stop_d;
         hit_cnt_q      <= hit_cnt_d;
         sample_valid_q <= sample_valid_d;
         x_l_q          <= x_l_d;
         x_r_q          <= x_r_d;
         gap_top_q      <= gap_top_d;
         gap_bot_q      <= gap_bot_d;
         bird_y_q       <= bird_y_d;
         score_q        <= score_d;
         final_q        <= final_d;
         best_q         <= best_d;
      end
   end

   assign Stop        = stop_q;
   assign Final_Score = final_q;
   assign Best_Score  = best_q;
   assign Q_Idle      = state_q[0];
   assign Q_Check     = state_q[1];
   assign Q_Hit       = state_q[2];

endmodule

// File: tb/tb_pipe_collision_ctrl.sv
// Directed bench for pipe_collision_ctrl: clear passes, confirmed hits, wrap-around pipe,
// floor strike, Q_Count drop and asynchronous reset, with hand-computed expectations.
module tb_pipe_collision_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       Tick = 1'b0, Q_Count = 1'b0, Ack = 1'b0;
   logic [9:0] X_Edge_L = '0, X_Edge_R = '0, Gap_Top = '0, Gap_Bot = '0, Bird_Y = '0;
   logic [3:0] Score = '0;
   logic       Stop, Q_Idle, Q_Check, Q_Hit;
   logic [3:0] Final_Score, Best_Score;

   int checks = 0;
   int errors = 0;

   pipe_collision_ctrl #(
      .BIRD_X(300), .BIRD_SIZE(20), .FLOOR_Y(460), .HIT_CONFIRM(2)
   ) dut (
      .clk(clk), .reset(reset), .Tick(Tick), .Q_Count(Q_Count), .Ack(Ack),
      .X_Edge_L(X_Edge_L), .X_Edge_R(X_Edge_R), .Gap_Top(Gap_Top), .Gap_Bot(Gap_Bot),
      .Bird_Y(Bird_Y), .Score(Score), .Stop(Stop), .Final_Score(Final_Score),
      .Best_Score(Best_Score), .Q_Idle(Q_Idle), .Q_Check(Q_Check), .Q_Hit(Q_Hit)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_geom(input int l, input int r, input int top, input int bot,
                           input int y, input int sc);
      X_Edge_L = 10'(l);
      X_Edge_R = 10'(r);
      Gap_Top  = 10'(top);
      Gap_Bot  = 10'(bot);
      Bird_Y   = 10'(y);
      Score    = 4'(sc);
   endtask

   // One Tick sample edge followed by its evaluate edge.
   task automatic tick_eval();
      Tick = 1'b1;
      cycle();
      Tick = 1'b0;
      cycle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      checks++; if (Stop !== 1'b0) begin errors++; $display("FAIL reset_stop: Stop=%b expected 0", Stop); end
      checks++; if (Final_Score !== 4'd0) begin errors++; $display("FAIL reset_final: got %0d expected 0", Final_Score); end
      checks++; if (Best_Score !== 4'd0) begin errors++; $display("FAIL reset_best: got %0d expected 0", Best_Score); end
      checks++; if ({Q_Hit, Q_Check, Q_Idle} !== 3'b001) begin errors++; $display("FAIL reset_state: got %b expected 001", {Q_Hit, Q_Check, Q_Idle}); end
      reset = 1'b0;
      cycle();
      checks++; if (Q_Idle !== 1'b1) begin errors++; $display("FAIL idle_hold: Q_Idle=%b expected 1 with Q_Count=0", Q_Idle); end
      Q_Count = 1'b1;
      cycle();
      checks++; if (Q_Check !== 1'b1) begin errors++; $display("FAIL enter_check: Q_Check=%b expected 1", Q_Check); end
   endtask

   task automatic test_clear_pass();
      set_geom(290, 370, 150, 300, 200, 0);
      for (int i = 0; i < 5; i++) begin
         tick_eval();
         cycle();
         checks++; if (Stop !== 1'b0 || Q_Check !== 1'b1) begin errors++; $display("FAIL clear_pass tick%0d: Stop=%b Q_Check=%b expected 0/1", i, Stop, Q_Check); end
      end
   endtask

   task automatic test_hit();
      set_geom(290, 370, 150, 300, 100, 3);
      tick_eval();
      checks++; if (Stop !== 1'b0) begin errors++; $display("FAIL hit_first_eval: Stop=%b expected 0", Stop); end
      cycle();
      cycle();
      Tick = 1'b1;
      cycle();
      Tick = 1'b0;
      checks++; if (Stop !== 1'b0) begin errors++; $display("FAIL hit_sample_edge: Stop=%b expected 0", Stop); end
      Ack = 1'b1;
      cycle();
      Ack = 1'b0;
      checks++; if (Stop !== 1'b1 || Q_Hit !== 1'b1) begin errors++; $display("FAIL hit_latency: Stop=%b Q_Hit=%b expected 1/1", Stop, Q_Hit); end
      checks++; if (Final_Score !== 4'd3) begin errors++; $display("FAIL hit_final: got %0d expected 3", Final_Score); end
      checks++; if (Best_Score !== 4'd3) begin errors++; $display("FAIL hit_best: got %0d expected 3", Best_Score); end
      cycle();
      checks++; if (Q_Hit !== 1'b1) begin errors++; $display("FAIL ack_on_entry: Q_Hit=%b expected 1", Q_Hit); end
      set_geom(290, 370, 150, 300, 200, 9);
      tick_eval();
      checks++; if (Final_Score !== 4'd3 || Stop !== 1'b1) begin errors++; $display("FAIL hit_tick_ignored: Final=%0d Stop=%b expected 3/1", Final_Score, Stop); end
   endtask

   task automatic test_ack();
      Q_Count = 1'b0;
      Ack = 1'b1;
      cycle();
      Ack = 1'b0;
      checks++; if (Q_Idle !== 1'b1 || Stop !== 1'b0) begin errors++; $display("FAIL ack_release: Q_Idle=%b Stop=%b expected 1/0", Q_Idle, Stop); end
      cycle();
      checks++; if (Q_Idle !== 1'b1) begin errors++; $display("FAIL ack_wait_count: Q_Idle=%b expected 1", Q_Idle); end
      Q_Count = 1'b1;
      cycle();
      checks++; if (Q_Check !== 1'b1) begin errors++; $display("FAIL ack_restart: Q_Check=%b expected 1", Q_Check); end
   endtask

   task automatic test_single_overlap();
      set_geom(290, 370, 150, 300, 100, 0);
      tick_eval();
      set_geom(290, 370, 150, 300, 200, 0);
      tick_eval();
      set_geom(290, 370, 150, 300, 100, 0);
      tick_eval();
      checks++; if (Stop !== 1'b0 || Q_Hit !== 1'b0) begin errors++; $display("FAIL single_overlap: Stop=%b Q_Hit=%b expected 0/0", Stop, Q_Hit); end
      set_geom(290, 370, 150, 300, 200, 0);
      tick_eval();
   endtask

   task automatic test_wrap();
      set_geom(635, 15, 150, 300, 100, 2);
      tick_eval();
      tick_eval();
      checks++; if (Stop !== 1'b0) begin errors++; $display("FAIL wrap_no_xhit: Stop=%b expected 0", Stop); end
      set_geom(280, 360, 150, 300, 100, 2);
      tick_eval();
      checks++; if (Stop !== 1'b0) begin errors++; $display("FAIL wrap_then_first: Stop=%b expected 0", Stop); end
      tick_eval();
      checks++; if (Stop !== 1'b1 || Final_Score !== 4'd2 || Best_Score !== 4'd3) begin errors++; $display("FAIL wrap_then_hit: Stop=%b Final=%0d Best=%0d expected 1/2/3", Stop, Final_Score, Best_Score); end
      Ack = 1'b1;
      cycle();
      Ack = 1'b0;
      cycle();
   endtask

   task automatic test_back_to_back();
      checks++; if (Q_Check !== 1'b1) begin errors++; $display("FAIL floor_pre_state: Q_Check=%b expected 1", Q_Check); end
      set_geom(500, 580, 150, 300, 445, 1);
      Tick = 1'b1;
      cycle();
      cycle();
      Tick = 1'b0;
      checks++; if (Stop !== 1'b0) begin errors++; $display("FAIL floor_first_eval: Stop=%b expected 0", Stop); end
      cycle();
      checks++; if (Stop !== 1'b1 || Q_Hit !== 1'b1) begin errors++; $display("FAIL floor_hit: Stop=%b Q_Hit=%b expected 1/1", Stop, Q_Hit); end
      checks++; if (Final_Score !== 4'd1 || Best_Score !== 4'd3) begin errors++; $display("FAIL floor_scores: Final=%0d Best=%0d expected 1/3", Final_Score, Best_Score); end
      Ack = 1'b1;
      cycle();
      Ack = 1'b0;
      checks++; if (Q_Idle !== 1'b1 || Stop !== 1'b0) begin errors++; $display("FAIL floor_ack: Q_Idle=%b Stop=%b expected 1/0", Q_Idle, Stop); end
      cycle();
   endtask

   task automatic test_qcount_drop();
      set_geom(290, 370, 150, 300, 100, 4);
      tick_eval();
      Tick = 1'b1;
      cycle();
      Tick = 1'b0;
      Q_Count = 1'b0;
      cycle();
      checks++; if (Q_Idle !== 1'b1 || Stop !== 1'b0) begin errors++; $display("FAIL drop_priority: Q_Idle=%b Stop=%b expected 1/0", Q_Idle, Stop); end
      cycle();
      Q_Count = 1'b1;
      cycle();
      tick_eval();
      checks++; if (Stop !== 1'b0 || Q_Check !== 1'b1) begin errors++; $display("FAIL drop_cnt_cleared: Stop=%b Q_Check=%b expected 0/1", Stop, Q_Check); end
      set_geom(290, 370, 150, 300, 200, 4);
      tick_eval();
   endtask

   task automatic test_reset_in_hit();
      set_geom(290, 370, 150, 300, 100, 6);
      tick_eval();
      tick_eval();
      checks++; if (Q_Hit !== 1'b1 || Best_Score !== 4'd6) begin errors++; $display("FAIL pre_reset_hit: Q_Hit=%b Best=%0d expected 1/6", Q_Hit, Best_Score); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (Stop !== 1'b0 || Q_Idle !== 1'b1 || Q_Hit !== 1'b0) begin errors++; $display("FAIL async_reset_state: Stop=%b Q_Idle=%b Q_Hit=%b expected 0/1/0", Stop, Q_Idle, Q_Hit); end
      checks++; if (Best_Score !== 4'd0 || Final_Score !== 4'd0) begin errors++; $display("FAIL async_reset_scores: Best=%0d Final=%0d expected 0/0", Best_Score, Final_Score); end
      cycle();
      reset = 1'b0;
      cycle();
   endtask

   initial begin
      test_reset();
      test_clear_pass();
      test_hit();
      test_ack();
      test_single_overlap();
      test_wrap();
      test_back_to_back();
      test_qcount_drop();
      test_reset_in_hit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
